// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: round-robin output-port arbiter for the NoC router.
// Grants one of NUM_PORTS channels at a time with a registered one-hot grant.
// Each grant lasts at most limit+1 cycles. The per-channel limit is loaded
// from the length field whenever that channel presents a header flit.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req          per-channel request, bit i = channel i
//   flit_id      packed per-channel flit type, channel i at [i*FLIT_ID_W +: FLIT_ID_W]
//   length       packed per-channel packet length (timeout limit in cycles)
//   grant        registered one-hot grant, all-zero when idle
//   grant_valid  registered OR-reduction of grant
//   timeout      one-cycle pulse: grant lost by timeout while still requesting
//   timeout_cnt  saturating 16-bit timeout count (only with ARB_TIMEOUT_CNT_EN)
//
// Optional feature macro: ARB_TIMEOUT_CNT_EN
module noc_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned FLIT_ID_W = 3,
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned HEADER_ID = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS*FLIT_ID_W-1:0] flit_id,
  input  logic [NUM_PORTS*LEN_W-1:0]     length,
  output logic [NUM_PORTS-1:0]           grant,
  output logic                           grant_valid,
  output logic                           timeout
`ifdef ARB_TIMEOUT_CNT_EN
  ,
  output logic [15:0]                    timeout_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]     last_ptr;
  logic [PTR_W-1:0]     last_ptr_next;
  logic [NUM_PORTS-1:0] grant_next;
  logic                 timeout_next;
  logic [NUM_PORTS-1:0] at_limit;

  // Per-channel limit and running count; count only advances while holding.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    logic [LEN_W-1:0] limit_r;
    logic [LEN_W-1:0] count_r;

    assign at_limit[g] = (count_r == limit_r);

    always_ff @(posedge clk) begin
      if (rst) begin
        limit_r <= '0;
        count_r <= '0;
      end else begin
        if (flit_id[g*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(HEADER_ID)) begin
          limit_r <= length[g*LEN_W +: LEN_W];
        end
        // Kept grant means hold; a new winner or non-granted channel restarts at 0.
        count_r <= (grant[g] && grant_next[g]) ? count_r + LEN_W'(1) : '0;
      end
    end
  end

  // Next-state: hold current grant or run the round-robin search.
  always_comb begin
    int unsigned start;
    int unsigned span;
    int unsigned best_d;
    int unsigned d;
    logic        cur_req;
    logic        cur_lim;
    logic [PTR_W-1:0] cur_idx;

    grant_next    = '0;
    last_ptr_next = last_ptr;
    timeout_next  = 1'b0;
    start         = 0;
    span          = NUM_PORTS;
    best_d        = NUM_PORTS;
    d             = 0;
    cur_req       = 1'b0;
    cur_lim       = 1'b0;
    cur_idx       = '0;

    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        cur_req = req[i];
        cur_lim = at_limit[i];
        cur_idx = PTR_W'(i);
      end
    end

    if (grant_valid && cur_req && !cur_lim) begin
      grant_next = grant;
    end else begin
      if (grant_valid) begin
        // Releasing channel is excluded from this cycle's search.
        start        = 32'(cur_idx) + 1;
        span         = NUM_PORTS - 1;
        timeout_next = cur_req;
      end else begin
        start = 32'(last_ptr) + 1;
      end
      // Distance from start in rotation order; smallest requesting distance wins.
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        d = (i + NUM_PORTS - start) % NUM_PORTS;
        if (req[i] && (d < span) && (d < best_d)) begin
          best_d        = d;
          grant_next    = NUM_PORTS'(1) << i;
          last_ptr_next = PTR_W'(i);
        end
      end
    end
  end

  // State register: grant is the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      last_ptr    <= PTR_W'(NUM_PORTS - 1);
    end else begin
      grant       <= grant_next;
      grant_valid <= |grant_next;
      timeout     <= timeout_next;
      last_ptr    <= last_ptr_next;
    end
  end

`ifdef ARB_TIMEOUT_CNT_EN
  // Saturating timeout counter, updated alongside the timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (timeout_next && (timeout_cnt != 16'hFFFF)) begin
      timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Testbench for noc_rr_arbiter (NUM_PORTS=5, LEN_W=12).
module tb_noc_rr_arbiter;

  localparam int unsigned NP  = 5;
  localparam int unsigned FW  = 3;
  localparam int unsigned LW  = 12;
  localparam int unsigned HID = 1;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req;
  logic [NP*FW-1:0]  flit_id;
  logic [NP*LW-1:0]  length;
  logic [NP-1:0]     grant;
  logic              grant_valid;
  logic              timeout;
`ifdef ARB_TIMEOUT_CNT_EN
  logic [15:0]       timeout_cnt;
`endif

  noc_rr_arbiter #(
    .NUM_PORTS(NP), .FLIT_ID_W(FW), .LEN_W(LW), .HEADER_ID(HID)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .grant(grant), .grant_valid(grant_valid), .timeout(timeout)
`ifdef ARB_TIMEOUT_CNT_EN
    , .timeout_cnt(timeout_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NP-1:0] req;
    logic [NP-1:0] hdr;
    logic [LW-1:0] len;
    logic [NP-1:0] exp_grant;
    logic          exp_to;
  } vec_t;

  typedef struct {
    logic [NP-1:0] grant;
    logic          to;
    int            id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_tcnt = 0;

  function automatic void add(input logic r, input logic [NP-1:0] q, input logic [NP-1:0] h,
                              input logic [LW-1:0] l, input logic [NP-1:0] g, input logic t);
    vec_t v;
    v.rst = r; v.req = q; v.hdr = h; v.len = l; v.exp_grant = g; v.exp_to = t;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic [NP-1:0] q, input logic [NP-1:0] h,
                       input logic [LW-1:0] l);
    rst = r;
    req = q;
    for (int i = 0; i < NP; i++) begin
      flit_id[i*FW +: FW] = h[i] ? FW'(HID) : '0;
      length[i*LW +: LW]  = l;
    end
  endtask

  task automatic check(input string name, input int id, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, id, act, expv);
    end
  endtask

  // Drive one vector, push its expectation, compare after the next edge.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    drive(v.rst, v.req, v.hdr, v.len);
    e.grant = v.exp_grant; e.to = v.exp_to; e.id = id;
    sb.push_back(e);
    if (v.rst) exp_tcnt = 0;
    else if (v.exp_to) exp_tcnt++;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard vec%0d: queue empty", id);
    end else begin
      e = sb.pop_front();
      check("grant", e.id, int'(grant), int'(e.grant));
      check("grant_valid", e.id, int'(grant_valid), int'(|e.grant));
      check("timeout", e.id, int'(timeout), int'(e.to));
`ifdef ARB_TIMEOUT_CNT_EN
      check("timeout_cnt", e.id, int'(timeout_cnt), exp_tcnt);
`endif
    end
  endtask

  initial begin
    int n_hold;
    int budget;
    vec_t v;

    drive(1'b1, '0, '0, '0);

    // reset
    add(1, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(1, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // limit 0 on ch0: grant / idle alternate, timeout on each release
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // header len 3 on ch0: 4 grant cycles, then one idle with timeout
    add(0, 5'b00001, 5'b00001, 3, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // req 10110, all limits 1: ch1,ch2,ch4,ch1 two cycles each, no gaps
    add(0, 5'b10110, 5'b11111, 1, 5'b00010, 0);
    add(0, 5'b10110, 5'b00000, 0, 5'b00010, 0);
    add(0, 5'b10110, 5'b00000, 0, 5'b00100, 1);
    add(0, 5'b10110, 5'b00000, 0, 5'b00100, 0);
    add(0, 5'b10110, 5'b00000, 0, 5'b10000, 1);
    add(0, 5'b10110, 5'b00000, 0, 5'b10000, 0);
    add(0, 5'b10110, 5'b00000, 0, 5'b00010, 1);
    add(0, 5'b10110, 5'b00000, 0, 5'b00010, 0);
    add(0, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // ch2 limit 10, req dropped in 3rd grant cycle: handover to ch0, no timeout
    add(0, 5'b00100, 5'b00100, 10, 5'b00100, 0);
    add(0, 5'b00100, 5'b00000, 0, 5'b00100, 0);
    add(0, 5'b00100, 5'b00000, 0, 5'b00100, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // reset during GRANT(3); first grant after goes to lowest index, limits lost
    add(0, 5'b01000, 5'b00000, 0, 5'b01000, 0);
    add(0, 5'b01000, 5'b00000, 0, 5'b01000, 0);
    add(1, 5'b01010, 5'b00000, 0, 5'b00000, 0);
    add(0, 5'b01010, 5'b00000, 0, 5'b00010, 0);
    add(0, 5'b01010, 5'b00000, 0, 5'b01000, 1);
    add(0, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // limit reload mid-grant (5 -> 2) applies to the next compare: 3 cycles
    add(0, 5'b00001, 5'b00001, 5, 5'b00001, 0);
    add(0, 5'b00001, 5'b00001, 2, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    add(0, 5'b00001, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b00000, 5'b00000, 0, 5'b00000, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Maximum limit on ch4: grant must last exactly 4096 cycles.
    v.rst = 0; v.req = 5'b10000; v.hdr = 5'b10000; v.len = 12'hFFF;
    v.exp_grant = 5'b10000; v.exp_to = 0;
    apply(v, 1000);
    drive(1'b0, 5'b10000, 5'b00000, '0);
    n_hold = 1;
    budget = 5000;
    while (budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (grant != 5'b10000) break;
      n_hold++;
    end
    if (budget == 0) begin
      n_tests++; n_fail++;
      $display("FAIL max_limit: grant never released within cycle budget");
    end
    exp_tcnt++;
    check("max_limit_cycles", 1001, n_hold, 4096);
    check("max_limit_grant", 1001, int'(grant), 0);
    check("max_limit_timeout", 1001, int'(timeout), 1);
`ifdef ARB_TIMEOUT_CNT_EN
    check("max_limit_tcnt", 1001, int'(timeout_cnt), exp_tcnt);
`endif
    drive(1'b0, 5'b00000, 5'b00000, '0);
    @(posedge clk); #1;
    check("max_limit_pulse_end", 1002, int'(timeout), 0);

    // Reset clears everything, including the optional counter.
    v.rst = 1; v.req = 5'b00000; v.hdr = 5'b00000; v.len = 0;
    v.exp_grant = 5'b00000; v.exp_to = 0;
    apply(v, 1003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
